// File: rtl/quadrilatero_rf_write_arbiter_if.sv
// Row-write bundle between the matrix units and the register-file write port.
// The master side is the environment: the units plus the register file's ready.
// The slave side is the arbiter.
interface quadrilatero_rf_write_arbiter_if #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned RLEN    = 128,
    parameter int unsigned N_REGS  = 8,
    parameter int unsigned N_ROWS  = 4
);
    localparam int unsigned AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    // Unit-side ports
    logic [N_PORTS-1:0]           we;
    logic [N_PORTS-1:0][AW-1:0]   waddr;
    logic [N_PORTS-1:0][RW-1:0]   wrowaddr;
    logic [N_PORTS-1:0][RLEN-1:0] wdata;
    logic [N_PORTS-1:0]           wlast;
    logic [N_PORTS-1:0]           wready;

    // Register-file side
    logic [AW-1:0]   rf_waddr;
    logic [RW-1:0]   rf_wrowaddr;
    logic [RLEN-1:0] rf_wdata;
    logic            rf_we;
    logic            rf_wready;

    modport master (
        output we, waddr, wrowaddr, wdata, wlast, rf_wready,
        input  wready, rf_waddr, rf_wrowaddr, rf_wdata, rf_we
    );

    modport slave (
        input  we, waddr, wrowaddr, wdata, wlast, rf_wready,
        output wready, rf_waddr, rf_wrowaddr, rf_wdata, rf_we
    );
endinterface

// File: rtl/quadrilatero_rf_write_arbiter.sv
// Merges the unit-side row-write ports into the single register-file write
// port. A burst locks its port from the first accepted beat to its wlast beat;
// idle arbitration is round-robin, advanced only on burst completion.
module quadrilatero_rf_write_arbiter #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned RLEN    = 128,
    parameter int unsigned N_REGS  = 8,
    parameter int unsigned N_ROWS  = 4,
    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    quadrilatero_rf_write_arbiter_if.slave     wr,
    output logic                               lock_valid_o,
    output logic [PW-1:0]                      owner_o,
    output logic [N_REGS-1:0]                  reg_busy_o,
    output logic                               protocol_err_o
);
    localparam int unsigned AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [RW-1:0] LastRow = RW'(N_ROWS - 1);

    if (N_PORTS < 2) begin : g_ports_chk
        $error("quadrilatero_rf_write_arbiter: N_PORTS must be >= 2");
    end
    if (N_ROWS < 2) begin : g_rows_chk
        $error("quadrilatero_rf_write_arbiter: N_ROWS must be >= 2");
    end

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [AW-1:0] lock_reg_q, lock_reg_d;
    logic [RW-1:0] exp_row_q, exp_row_d;
    logic          err_q, err_d;

    logic [PW-1:0] sel;
    logic          sel_valid;
    logic [PW-1:0] cand;
    logic          acc;
    logic [AW-1:0] beat_addr;
    logic [RW-1:0] beat_row;
    logic          beat_last;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (32'(p) == N_PORTS - 1) ? '0 : p + PW'(1);
    endfunction

    // Pick the port to forward: the lock owner, or the first requester from rr_ptr_q
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        cand      = '0;
        if (state_q == StLocked) begin
            sel       = owner_q;
            sel_valid = wr.we[owner_q];
        end else begin
            for (int i = 0; i < int'(N_PORTS); i++) begin
                cand = PW'((32'(rr_ptr_q) + 32'(i)) % N_PORTS);
                if (!sel_valid && wr.we[cand]) begin
                    sel_valid = 1'b1;
                    sel       = cand;
                end
            end
        end
    end

    // Forward the selected port's beat and route the register-file ready back to it
    always_comb begin
        wr.wready      = '0;
        wr.rf_we       = sel_valid;
        wr.rf_waddr    = sel_valid ? wr.waddr[sel]    : '0;
        wr.rf_wrowaddr = sel_valid ? wr.wrowaddr[sel] : '0;
        wr.rf_wdata    = sel_valid ? wr.wdata[sel]    : '0;
        if (sel_valid) begin
            wr.wready[sel] = wr.rf_wready;
        end
        beat_addr = wr.waddr[sel];
        beat_row  = wr.wrowaddr[sel];
        beat_last = wr.wlast[sel];
        acc       = sel_valid & wr.rf_wready;
    end

    // State register; reset abandons any burst in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_reg_q <= '0;
            exp_row_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_reg_q <= lock_reg_d;
            exp_row_q  <= exp_row_d;
            err_q      <= err_d;
        end
    end

    // Burst sequencing and protocol check on every accepted beat
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_reg_d = lock_reg_q;
        exp_row_d  = exp_row_q;
        // exp_row_q is held at 0 while idle, so the first-beat check falls out naturally
        err_d = acc && ((beat_row != exp_row_q) ||
                        (beat_last && (exp_row_q != LastRow)) ||
                        (!beat_last && (exp_row_q == LastRow)) ||
                        ((state_q == StLocked) && (beat_addr != lock_reg_q)));
        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    if (beat_last) begin
                        rr_ptr_d = next_port(sel);
                    end else begin
                        state_d    = StLocked;
                        owner_d    = sel;
                        lock_reg_d = beat_addr;
                        exp_row_d  = beat_row + RW'(1);
                    end
                end
            end
            StLocked: begin
                if (acc) begin
                    if (beat_last) begin
                        state_d   = StIdle;
                        rr_ptr_d  = next_port(owner_q);
                        exp_row_d = '0;
                    end else begin
                        exp_row_d = exp_row_q + RW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Lock status seen by the scoreboard
    always_comb begin
        lock_valid_o   = (state_q == StLocked);
        owner_o        = lock_valid_o ? owner_q : '0;
        reg_busy_o     = lock_valid_o ? (N_REGS'(1) << lock_reg_q) : '0;
        protocol_err_o = err_q;
    end
endmodule
